// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared widths and state encoding for the memory responder
package mem_resp_pkg;
    localparam int DATA_W = 32;
    localparam int BUS_ADDR_W = 24;
    localparam int CNT_W = 4;
    typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, REFRESH} state_t;
endpackage

// File: rtl/mem_resp_ram.sv
// mem_resp_ram: single-port synchronous RAM, read returns the old word on a same-cycle write
module mem_resp_ram
    import mem_resp_pkg::*;
#(
    parameter int ADDR_BITS = 12
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [DATA_W-1:0]    wdata,
    output logic [DATA_W-1:0]    rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_BITS];

    // registered read of the addressed word, optional write of the same word
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency DRAM-like responder; optional refresh stalls under MEM_RESP_REFRESH_EN
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_BITS        = 12,
    parameter int READ_LATENCY     = 4,
    parameter int WRITE_LATENCY    = 3,
    parameter int REFRESH_INTERVAL = 512,
    parameter int REFRESH_CYCLES   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BUS_ADDR_W-1:0] dram_addr,
    input  logic [DATA_W-1:0]     dram_data_in,
    input  logic                  dram_req_read,
    input  logic                  dram_req_write,
    output logic [DATA_W-1:0]     dram_data_out,
    output logic                  dram_data_out_valid,
    output logic                  dram_write_complete,
    output logic                  busy,
    output logic                  req_dropped
);
    state_t state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [ADDR_BITS-1:0] lat_addr, lat_addr_n, ram_addr;
    logic [DATA_W-1:0] lat_data, lat_data_n, ram_q, data_n;
    logic wr_pend, wr_pend_n, valid_n, wc_n, dropped_n, go, go_wr, latch, req_any, use_in;
    logic unused_hi;
`ifdef MEM_RESP_REFRESH_EN
    localparam int RF_W = $clog2(REFRESH_INTERVAL);
    localparam int RC_W = $clog2(REFRESH_CYCLES + 1);
    logic [RF_W-1:0] rf_cnt;
    logic [RC_W-1:0] rc_cnt, rc_cnt_n;
    logic due, due_n, pend, pend_n, pend_wr, pend_wr_n;
    assign use_in = state == IDLE || (state == REFRESH && !pend);
`else
    assign use_in = state == IDLE;
`endif

    assign req_any = dram_req_read | dram_req_write;
    assign busy = state != IDLE;
    assign unused_hi = ^dram_addr[BUS_ADDR_W-1:ADDR_BITS];
    assign ram_addr = (wr_pend || !use_in) ? lat_addr : dram_addr[ADDR_BITS-1:0];

    mem_resp_ram #(.ADDR_BITS(ADDR_BITS)) u_ram (
        .clk   (clk),
        .we    (wr_pend & ~rst),
        .addr  (ram_addr),
        .wdata (lat_data),
        .rdata (ram_q)
    );

    // next state: accept, count down latency, refresh stall; go starts a request with this edge as T
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        lat_addr_n = lat_addr;
        lat_data_n = lat_data;
        data_n = dram_data_out;
        valid_n = 1'b0;
        wc_n = 1'b0;
        wr_pend_n = 1'b0;
        dropped_n = req_dropped | (req_any && (state == READ_WAIT || state == WRITE_WAIT));
        go = 1'b0;
        go_wr = dram_req_write;
        latch = 1'b0;
`ifdef MEM_RESP_REFRESH_EN
        rc_cnt_n = rc_cnt;
        due_n = due | (rf_cnt == RF_W'(REFRESH_INTERVAL - 1));
        pend_n = pend;
        pend_wr_n = pend_wr;
`endif
        case (state)
            IDLE: begin
`ifdef MEM_RESP_REFRESH_EN
                if (due) begin
                    state_n = REFRESH;
                    rc_cnt_n = RC_W'(REFRESH_CYCLES - 1);
                    due_n = 1'b0;
                    latch = req_any;
                    pend_n = req_any;
                    pend_wr_n = dram_req_write;
                end else begin
                    latch = req_any;
                    go = req_any;
                end
`else
                latch = req_any;
                go = req_any;
`endif
            end
            READ_WAIT: begin
                if (cnt == 1) begin
                    state_n = IDLE;
                    valid_n = 1'b1;
                    data_n = ram_q;
                end else cnt_n = cnt - 1'b1;
            end
            WRITE_WAIT: begin
                if (cnt == 1) begin
                    state_n = IDLE;
                    wc_n = 1'b1;
                end else cnt_n = cnt - 1'b1;
            end
`ifdef MEM_RESP_REFRESH_EN
            REFRESH: begin
                latch = !pend && req_any;
                dropped_n = req_dropped | (pend && req_any);
                if (rc_cnt == 0) begin
                    state_n = IDLE;
                    pend_n = 1'b0;
                    go = pend | req_any;
                    go_wr = pend ? pend_wr : dram_req_write;
                end else begin
                    rc_cnt_n = rc_cnt - 1'b1;
                    pend_n = pend | req_any;
                    pend_wr_n = pend ? pend_wr : dram_req_write;
                end
            end
`endif
            default: ;
        endcase
        if (latch) begin
            lat_addr_n = dram_addr[ADDR_BITS-1:0];
            lat_data_n = dram_data_in;
        end
        if (go) begin
            state_n = go_wr ? (WRITE_LATENCY == 1 ? IDLE : WRITE_WAIT) : READ_WAIT;
            cnt_n = go_wr ? CNT_W'(WRITE_LATENCY - 1) : CNT_W'(READ_LATENCY - 1);
            wc_n = go_wr && WRITE_LATENCY == 1;
            wr_pend_n = go_wr;
        end
    end

    // state and output registers; reset discards any in-flight request
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            lat_addr <= '0;
            lat_data <= '0;
            wr_pend <= 1'b0;
            dram_data_out <= '0;
            dram_data_out_valid <= 1'b0;
            dram_write_complete <= 1'b0;
            req_dropped <= 1'b0;
`ifdef MEM_RESP_REFRESH_EN
            rc_cnt <= '0;
            due <= 1'b0;
            pend <= 1'b0;
            pend_wr <= 1'b0;
`endif
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            lat_addr <= lat_addr_n;
            lat_data <= lat_data_n;
            wr_pend <= wr_pend_n;
            dram_data_out <= data_n;
            dram_data_out_valid <= valid_n;
            dram_write_complete <= wc_n;
            req_dropped <= dropped_n;
`ifdef MEM_RESP_REFRESH_EN
            rc_cnt <= rc_cnt_n;
            due <= due_n;
            pend <= pend_n;
            pend_wr <= pend_wr_n;
`endif
        end
    end

`ifdef MEM_RESP_REFRESH_EN
    // free-running refresh interval counter
    always_ff @(posedge clk) begin
        if (rst) rf_cnt <= '0;
        else rf_cnt <= (rf_cnt == RF_W'(REFRESH_INTERVAL - 1)) ? '0 : rf_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench for mem_responder (refresh scenario when MEM_RESP_REFRESH_EN is defined)
module tb_mem_responder;
    localparam int AB = 12;
    localparam int RL = 4;
    localparam int WL = 3;
`ifdef MEM_RESP_REFRESH_EN
    localparam int RI = 16;
    localparam int RC = 4;
`else
    localparam int RI = 512;
    localparam int RC = 8;
`endif

    logic clk = 1'b0, rst = 1'b1;
    logic [23:0] dram_addr = '0;
    logic [31:0] dram_data_in = '0;
    logic dram_req_read = 1'b0, dram_req_write = 1'b0;
    logic [31:0] dram_data_out;
    logic dram_data_out_valid, dram_write_complete, busy, req_dropped;

    int checks = 0, errors = 0, cyc = 0;
    int rd_cyc_q[$], wr_cyc_q[$];
    logic [31:0] rd_dat_q[$];
    logic [31:0] mem_m [4096];

    mem_responder #(
        .ADDR_BITS(AB), .READ_LATENCY(RL), .WRITE_LATENCY(WL),
        .REFRESH_INTERVAL(RI), .REFRESH_CYCLES(RC)
    ) dut (
        .clk(clk), .rst(rst), .dram_addr(dram_addr), .dram_data_in(dram_data_in),
        .dram_req_read(dram_req_read), .dram_req_write(dram_req_write),
        .dram_data_out(dram_data_out), .dram_data_out_valid(dram_data_out_valid),
        .dram_write_complete(dram_write_complete), .busy(busy), .req_dropped(req_dropped)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // drive a one-cycle request; lat=0 means the nominal latency of its type
    task automatic issue(input logic rd, input logic wr, input logic [23:0] a, input logic [31:0] d,
                         input bit expect_resp, input int lat);
        dram_addr = a;
        dram_data_in = d;
        dram_req_read = rd;
        dram_req_write = wr;
        if (expect_resp) begin
            if (wr) begin
                mem_m[a[AB-1:0]] = d;
                wr_cyc_q.push_back(cyc + (lat != 0 ? lat : WL));
            end else begin
                rd_cyc_q.push_back(cyc + (lat != 0 ? lat : RL));
                rd_dat_q.push_back(mem_m[a[AB-1:0]]);
            end
        end
        tick(1);
        dram_req_read = 1'b0;
        dram_req_write = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (rd_cyc_q.size() + wr_cyc_q.size()) != 0; i++) tick(1);
        check("drain", rd_cyc_q.size() + wr_cyc_q.size(), 0);
        tick(1);
    endtask

    // response monitor: compare pulses against the scoreboard away from the active edge
    always @(negedge clk) begin
        if (dram_data_out_valid) begin
            if (rd_cyc_q.size() == 0) check("unexpected_valid", dram_data_out_valid, 1'b0);
            else begin
                check("rd_cycle", cyc, rd_cyc_q.pop_front());
                check("rd_data", dram_data_out, rd_dat_q.pop_front());
            end
        end
        if (dram_write_complete) begin
            if (wr_cyc_q.size() == 0) check("unexpected_wc", dram_write_complete, 1'b0);
            else check("wr_cycle", cyc, wr_cyc_q.pop_front());
        end
        if (dram_data_out_valid || dram_write_complete)
            check("pulse_excl", dram_data_out_valid & dram_write_complete, 1'b0);
        if (rd_cyc_q.size() != 0 && cyc > rd_cyc_q[0]) begin
            check("rd_missing", cyc, rd_cyc_q.pop_front());
            void'(rd_dat_q.pop_front());
        end
        if (wr_cyc_q.size() != 0 && cyc > wr_cyc_q[0]) check("wr_missing", cyc, wr_cyc_q.pop_front());
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] a;
        logic [31:0] d;
        tick(3);
        rst = 1'b0;
        check("rst_data", dram_data_out, 0);
        check("rst_valid", dram_data_out_valid, 0);
        check("rst_wc", dram_write_complete, 0);
        check("rst_busy", busy, 0);
        check("rst_dropped", req_dropped, 0);
`ifdef MEM_RESP_REFRESH_EN
        issue(1'b0, 1'b1, 24'h000040, 32'h0BADCAFE, 1'b1, 0);
        drain();
        for (int i = 0; i < 40 && busy; i++) tick(1);
        for (int i = 0; i < 40 && !busy; i++) tick(1);
        check("refresh_seen", busy, 1);
        tick(1);
        issue(1'b1, 1'b0, 24'h000040, 32'h0, 1'b1, RC + RL - 2);
        issue(1'b1, 1'b0, 24'h000040, 32'h0, 1'b0, 0);
        check("refresh_busy", busy, 1);
        drain();
        check("refresh_data", dram_data_out, 32'h0BADCAFE);
        check("refresh_dropped", req_dropped, 1);
`else
        issue(1'b0, 1'b1, 24'h000010, 32'hDEADBEEF, 1'b1, 0);
        check("busy_wr", busy, 1);
        drain();
        issue(1'b1, 1'b0, 24'h000010, 32'h0, 1'b1, 0);
        check("busy_rd", busy, 1);
        drain();
        check("rw_data", dram_data_out, 32'hDEADBEEF);
        issue(1'b0, 1'b1, 24'h000020, 32'h12345678, 1'b1, 0);
        tick(WL - 1);
        check("b2b_wc_now", dram_write_complete, 1);
        check("b2b_idle", busy, 0);
        issue(1'b1, 1'b0, 24'h000020, 32'h0, 1'b1, 0);
        drain();
        check("b2b_dropped", req_dropped, 0);
        issue(1'b0, 1'b1, 24'h001005, 32'hCAFEF00D, 1'b1, 0);
        drain();
        issue(1'b1, 1'b0, 24'h000005, 32'h0, 1'b1, 0);
        drain();
        check("wrap_data", dram_data_out, 32'hCAFEF00D);
        for (int i = 0; i < 6; i++) begin
            a = 24'($urandom);
            d = $urandom;
            issue(1'b0, 1'b1, a, d, 1'b1, 0);
            tick(WL - 1);
            issue(1'b1, 1'b0, {12'($urandom), a[11:0]}, 32'h0, 1'b1, 0);
            drain();
        end
        issue(1'b1, 1'b1, 24'h000030, 32'hA5A5A5A5, 1'b1, 0);
        drain();
        issue(1'b1, 1'b0, 24'h000030, 32'h0, 1'b1, 0);
        drain();
        check("both_is_write", dram_data_out, 32'hA5A5A5A5);
        check("no_drop_yet", req_dropped, 0);
        issue(1'b1, 1'b0, 24'h000010, 32'h0, 1'b1, 0);
        tick(1);
        issue(1'b1, 1'b0, 24'h000020, 32'h0, 1'b0, 0);
        drain();
        check("drop_set", req_dropped, 1);
        check("drop_data", dram_data_out, 32'hDEADBEEF);
        tick(5);
        check("drop_sticky", req_dropped, 1);
        issue(1'b1, 1'b0, 24'h000030, 32'h0, 1'b0, 0);
        tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("mid_rst_data", dram_data_out, 0);
        check("mid_rst_valid", dram_data_out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_dropped", req_dropped, 0);
        tick(6);
        rst = 1'b1;
        dram_addr = 24'h000010;
        dram_req_read = 1'b1;
        tick(1);
        rst = 1'b0;
        dram_req_read = 1'b0;
        check("rst_req_busy", busy, 0);
        tick(6);
        check("rst_req_dropped", req_dropped, 0);
        issue(1'b1, 1'b0, 24'h000010, 32'h0, 1'b1, 0);
        drain();
        check("ram_kept", dram_data_out, 32'hDEADBEEF);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
